mem_rd_responder: RTL
=====================

# mem_rd_responder

Target-side responder for the two-cycle `rd` / `ws` / `ds` read handshake used by the memory-read controller FSM. It samples `rd` and the read address, holds off the initiator with `ws` for a per-transaction programmable number of cycles, then presents registered read data from a small internal array until the initiator drops `rd`. A synchronous write port preloads the array. A wrapping counter reports completed reads.

## Interface
- `DW`, default 8: read/write data width.
- `AW`, default 4: address width; array depth is 2^AW words.
- `WW`, default 4: width of the wait-cycle configuration.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd`  in  1  read request from the initiator; high for the whole transaction, low in its done (`ds`) cycle.
- `addr`  in  AW  read address; stable while `rd`=1.
- `wait_cfg`  in  WW  number of `ws` cycles for the next transaction; sampled at start.
- `we`  in  1  array write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  DW  write data.
- `ws`  out  1  wait state to the initiator; 1 = data not ready.
- `rvalid`  out  1  read data valid.
- `rdata`  out  DW  registered read data.
- `txn_cnt`  out  16  count of completed reads; wraps at 0xFFFF to 0.

## Operation
- States: R_IDLE, R_WAIT, R_DATA. Outputs decode from state only (Moore): `ws` = (state==R_WAIT), `rvalid` = (state==R_DATA).
- R_IDLE:
  - `rd`=0: stay.
  - `rd`=1: capture `addr` into addr_q.
  - If `wait_cfg`=0, go to R_DATA and load `rdata` from mem[addr].
  - Otherwise go to R_WAIT and load cnt = `wait_cfg`.
- R_WAIT:
  - `rd`=0: abort to R_IDLE; `rdata` and `txn_cnt` unchanged.
  - Else if cnt==1: go to R_DATA and load `rdata` from mem[addr_q].
  - Else cnt decrements by 1.
- R_DATA:
  - `rd`=1: stay; `rdata` held.
  - `rd`=0: go to R_IDLE and increment `txn_cnt` (wraps modulo 2^16).
- `ws` is high for exactly `wait_cfg` consecutive cycles per non-aborted transaction.
- `rdata` holds its last loaded value in every state.
- Array writes are synchronous: `we`=1 writes `wdata` to mem[`waddr`] at the edge, in any state.
- Array contents are not reset.
- Read/write collision: the array read at the edge entering R_DATA uses contents from before that edge. A same-edge write to the same address is not seen by that read; later reads see it.
- `addr` changing during R_WAIT or R_DATA has no effect; only addr_q is used.
- `rd` high again in the cycle after a return to R_IDLE starts a new transaction normally.

## Timing
- Reset (`rst_n`=0, asynchronous): state=R_IDLE, cnt=0, `ws`=0, `rvalid`=0, `rdata`=0, `txn_cnt`=0. It takes effect immediately, including mid-transaction. Operation resumes on the first edge after `rst_n` rises.
- Let t0 be the first cycle with `rd`=1 (initiator S1):
  - `ws` goes high in t1 when `wait_cfg`≥1.
  - `rvalid` goes high in cycle t0+1+`wait_cfg`.
- The initiator samples `ws` in its S2 cycle, so `ws` must be valid at t1. This is met because `ws` is registered state decode.
- `rdata` is valid in every cycle with `rvalid`=1, including the initiator's `ds` cycle.
- Request-to-data latency is 1+`wait_cfg` cycles, with no combinational path from `rd` to `ws`, `rvalid` or `rdata`.

## Test plan
- Reset, then write mem[3]=0xA5. Drive `rd`=1 with `addr`=3 and `wait_cfg`=0, and drop `rd` two cycles later. Required: `ws` stays 0; `rvalid`=1 and `rdata`=0xA5 in cycles t1–t2; `txn_cnt`=1.
- Same read with `wait_cfg`=3. Required: `ws`=1 in exactly t1–t3; `rvalid` rises at t4 with `rdata`=0xA5; no change before t4.
- Run the initiator FSM model against the block with `wait_cfg`=2. Required: the initiator loops S2→S1 while `ws`=1; `ds` coincides with `rvalid`=1 and the correct data; both return to idle together.
- Abort by dropping `rd` at t2 with `wait_cfg`=4. Required: return to R_IDLE at the next edge; `ws`=0; `rvalid` never asserted; `rdata` and `txn_cnt` unchanged.
- Collision: with `wait_cfg`=1 and mem[5]=0x11, write 0x22 to address 5 on the edge entering R_DATA. Required: `rdata`=0x11. The next read of address 5 returns 0x22.
- Assert `rst_n`=0 while in R_WAIT and again while in R_DATA. Required: all outputs go to their reset values immediately, asynchronously to `clk`. Separately, complete 65536 reads. Required: `txn_cnt` wraps to 0.

Source files
------------

// File: rtl/mem_rd_responder.sv
`default_nettype none
// ============================================================================
// mem_rd_responder : target-side responder for the rd/ws/ds read handshake
// Revision: 1.0
// ============================================================================
module mem_rd_responder #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wait_cfg,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ws,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic [15:0]   txn_cnt
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } state_t;

  localparam int c_DEPTH = 1 << AW;

  state_t        r_state;
  logic [WW-1:0] r_cnt;
  logic [AW-1:0] r_addr_q;
  logic [DW-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // ws/rvalid are registered alongside the state so they equal its decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      ws       <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      txn_cnt  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd) begin
            r_addr_q <= addr;
            if (wait_cfg == '0) begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rdata   <= r_mem[addr];
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= wait_cfg;
              ws      <= 1'b1;
            end
          end
        end
        R_WAIT: begin
          if (!rd) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            ws      <= 1'b0;
          end else if (r_cnt == WW'(1)) begin
            r_state <= R_DATA;
            r_cnt   <= '0;
            ws      <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= r_mem[r_addr_q];
          end else begin
            r_cnt <= r_cnt - WW'(1);
          end
        end
        R_DATA: begin
          if (!rd) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            txn_cnt <= txn_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= R_IDLE;
          ws      <= 1'b0;
          rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
